// File: rtl/ibex_dmem_responder.sv
// Memory-side responder for the Ibex LSU data port: fixed-latency, in-order responses, bounded outstanding count, range errors.
// Optional grant back-pressure is compiled in with the IBEX_DMEM_RESP_GNT_STALL_EN macro.
module ibex_dmem_responder #(
  parameter int unsigned Depth          = 65536,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StallPeriod    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);
  localparam logic [32:0] Span = 33'(Depth) << 2;

  logic [31:0]         mem [Depth];
  logic [31:0]         offset;
  logic                in_range;
  logic [IdxW-1:0]     idx;
  logic                accept;
  logic                retire;
  logic                stall;
  logic [OutW-1:0]     outst;
  logic [31:0]         rd_data;
  logic [Latency-1:0]  vld_p;
  logic [31:0]         rdata_p [Latency];
  logic                err_p   [Latency];
  logic                unused_offset;

  // Wrapping subtraction makes addresses below BaseAddr land out of range too.
  assign offset        = addr_i - BaseAddr;
  assign in_range      = {1'b0, offset} < Span;
  assign idx           = offset[IdxW+1:2];
  assign unused_offset = ^offset;

`ifdef IBEX_DMEM_RESP_GNT_STALL_EN
  localparam int unsigned StallW = $clog2(StallPeriod);
  localparam logic [StallW-1:0] StallLast = StallW'(StallPeriod - 1);

  logic [StallW-1:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (stall_cnt == StallLast) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + StallW'(1);
    end
  end

  assign stall = (stall_cnt == StallLast);
`else
  logic unused_stall_period;
  assign unused_stall_period = (StallPeriod != 0);
  assign stall = 1'b0;
`endif

  // A slot freed by this cycle's response may be reused by this cycle's request.
  assign gnt_o  = rst_ni & req_i & ((outst < MaxOut) | retire) & ~stall;
  assign accept = req_i & gnt_o;
  assign retire = vld_p[Latency-1];

  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rd_data = (!we_i && in_range) ? mem[idx] : '0;

  // Stage p0 captures the accepted transaction; later stages shift toward the output.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int unsigned i = 1; i < Latency; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_p[0] <= rd_data;
    err_p[0]   <= ~in_range;
    for (int unsigned i = 1; i < Latency; i++) begin
      rdata_p[i] <= rdata_p[i-1];
      err_p[i]   <= err_p[i-1];
    end
  end

  // Output stage: data path is not reset, so gate it with the valid bit.
  assign rvalid_o = retire;
  assign rdata_o  = retire ? rdata_p[Latency-1] : '0;
  assign err_o    = retire & err_p[Latency-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   outst <= outst + OutW'(1);
        2'b01:   outst <= outst - OutW'(1);
        default: outst <= outst;
      endcase
    end
  end

  outst_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outst <= MaxOut);
  outst_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(retire && !accept && (outst == '0)));

endmodule

// File: tb/tb_ibex_dmem_responder.sv
// Directed bench for ibex_dmem_responder: four instances with different latency/depth/base settings share the request bus.
module tb_ibex_dmem_responder;

  logic        clk_i;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        rst_a, rst_b, rst_c, rst_d;
  logic        gnt_a, gnt_b, gnt_c, gnt_d;
  logic        rvalid_a, rvalid_b, rvalid_c, rvalid_d;
  logic        err_a, err_b, err_c, err_d;
  logic [31:0] rdata_a, rdata_b, rdata_c, rdata_d;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:5]  exp_gnt_b = 6'b110110;
  logic [0:8]  exp_rv_b  = 9'b000110110;
  logic [31:0] rd_addr_b [6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
  logic [31:0] exp_rd_b  [9] = '{32'h0, 32'h0, 32'h0, 32'hB0B0_0000, 32'hB1B1_1111,
                                 32'h0, 32'hB2B2_2222, 32'hB0B0_0000, 32'h0};
  logic [31:0] tp_addr   [4] = '{32'h10, 32'h20, 32'h0, 32'h10};
  logic [31:0] tp_rd     [5] = '{32'h0, 32'hDEAD_BEEF, 32'h11BB_33DD, 32'h5A5A_1234, 32'hDEAD_BEEF};

  ibex_dmem_responder #(.Depth(16), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(2),
                        .StallPeriod(1000)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_a), .req_i(req), .gnt_o(gnt_a), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a));

  ibex_dmem_responder #(.Depth(16), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(2),
                        .StallPeriod(1000)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_b), .req_i(req), .gnt_o(gnt_b), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b));

  ibex_dmem_responder #(.Depth(16), .BaseAddr(32'h1000), .Latency(4), .MaxOutstanding(2),
                        .StallPeriod(1000)) dut_c (
    .clk_i(clk_i), .rst_ni(rst_c), .req_i(req), .gnt_o(gnt_c), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c));

  ibex_dmem_responder #(.Depth(16), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(2),
                        .StallPeriod(4)) dut_d (
    .clk_i(clk_i), .rst_ni(rst_d), .req_i(req), .gnt_o(gnt_d), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_d), .rdata_o(rdata_d), .err_o(err_d));

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [31:0] a, input logic [31:0] d);
    logic done;
    done  = 1'b0;
    req   = 1'b1;
    we    = 1'b1;
    be    = 4'hF;
    addr  = a;
    wdata = d;
    for (int i = 0; i < 8 && !done; i++) begin
      smp();
      if (gnt_b) done = 1'b1;
      nxt();
    end
    req = 1'b0;
    we  = 1'b0;
    chkb("load_b_granted", done, 1'b1);
  endtask

  initial begin
    int  acc;
    logic eg;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

    // Reset state and grant suppression while in reset
    nxt();
    smp();
    chkb("rst_gnt", gnt_a, 1'b0);
    chkb("rst_rvalid", rvalid_a, 1'b0);
    chk ("rst_rdata", rdata_a, 32'h0);
    chkb("rst_err", err_a, 1'b0);
    nxt();
    req = 1'b1;
    smp();
    chkb("rst_gnt_forced", gnt_a, 1'b0);
    nxt();

    // Write then read back, latency 1
    rst_a = 1'b1; we = 1'b1; addr = 32'h10; be = 4'hF; wdata = 32'hDEAD_BEEF;
    smp();
    chkb("wr_gnt", gnt_a, 1'b1);
    nxt();
    we = 1'b0;
    smp();
    chkb("rd_gnt", gnt_a, 1'b1);
    chkb("wr_rsp_valid", rvalid_a, 1'b1);
    chkb("wr_rsp_err", err_a, 1'b0);
    chk ("wr_rsp_rdata", rdata_a, 32'h0);
    nxt();
    req = 1'b0;
    smp();
    chkb("rd_rsp_valid", rvalid_a, 1'b1);
    chk ("rd_rsp_rdata", rdata_a, 32'hDEAD_BEEF);
    chkb("rd_rsp_err", err_a, 1'b0);
    nxt();
    smp();
    chkb("idle_rvalid", rvalid_a, 1'b0);
    nxt();

    // Byte enables
    req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'h1122_3344;
    nxt();
    be = 4'b0101; wdata = 32'hAABB_CCDD;
    nxt();
    we = 1'b0; be = 4'h0;
    nxt();
    req = 1'b0;
    smp();
    chkb("be_rd_valid", rvalid_a, 1'b1);
    chk ("be_rd_rdata", rdata_a, 32'h11BB_33DD);
    nxt();

    // Out of range with Depth 16
    req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF; wdata = 32'h5A5A_1234;
    nxt();
    we = 1'b0; addr = 32'h40;
    nxt();
    we = 1'b1; addr = 32'h40; wdata = 32'hFFFF_FFFF;
    smp();
    chkb("oor_rd_valid", rvalid_a, 1'b1);
    chkb("oor_rd_err", err_a, 1'b1);
    chk ("oor_rd_rdata", rdata_a, 32'h0);
    nxt();
    we = 1'b0; addr = 32'h0;
    smp();
    chkb("oor_wr_valid", rvalid_a, 1'b1);
    chkb("oor_wr_err", err_a, 1'b1);
    nxt();
    req = 1'b0;
    smp();
    chkb("word0_valid", rvalid_a, 1'b1);
    chkb("word0_err", err_a, 1'b0);
    chk ("word0_rdata", rdata_a, 32'h5A5A_1234);
    nxt();

    // Latency 1 back-to-back throughput
    for (int k = 0; k < 5; k++) begin
      req = (k < 4);
      if (k < 4) addr = tp_addr[k];
      smp();
      chkb("tp_gnt", gnt_a, (k < 4));
      chkb("tp_rvalid", rvalid_a, (k >= 1));
      chk ("tp_rdata", rdata_a, tp_rd[k]);
      nxt();
    end
    rst_a = 1'b0;

    // Latency 3, two outstanding: preload, drain, then six back-to-back read requests
    rst_b = 1'b1;
    load_b(32'h0, 32'hB0B0_0000);
    load_b(32'h4, 32'hB1B1_1111);
    load_b(32'h8, 32'hB2B2_2222);
    for (int k = 0; k < 5; k++) nxt();
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      req = (k < 6);
      if (k < 6) addr = rd_addr_b[acc];
      smp();
      if (k < 6) chkb("lim_gnt", gnt_b, exp_gnt_b[k]);
      chkb("lim_rvalid", rvalid_b, exp_rv_b[k]);
      chk ("lim_rdata", rdata_b, exp_rd_b[k]);
      if (k < 6 && exp_gnt_b[k]) acc++;
      nxt();
    end
    req = 1'b0;
    rst_b = 1'b0;

    // Latency 4, reset while two reads are in flight
    rst_c = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h1000;
    smp();
    chkb("mid_gnt0", gnt_c, 1'b1);
    nxt();
    addr = 32'h1004;
    smp();
    chkb("mid_gnt1", gnt_c, 1'b1);
    nxt();
    req = 1'b0; rst_c = 1'b0;
    nxt();
    smp();
    chkb("mid_rst_rvalid", rvalid_c, 1'b0);
    nxt();
    rst_c = 1'b1; req = 1'b1; addr = 32'h1000;
    smp();
    chkb("mid_post_gnt", gnt_c, 1'b1);
    chkb("mid_c4_rvalid", rvalid_c, 1'b0);
    nxt();
    addr = 32'h0FFC;
    smp();
    chkb("below_base_gnt", gnt_c, 1'b1);
    chkb("mid_c5_rvalid", rvalid_c, 1'b0);
    nxt();
    req = 1'b0;
    smp();
    chkb("mid_c6_rvalid", rvalid_c, 1'b0);
    nxt();
    smp();
    chkb("mid_c7_rvalid", rvalid_c, 1'b0);
    nxt();
    smp();
    chkb("post_rsp_valid", rvalid_c, 1'b1);
    chkb("post_rsp_err", err_c, 1'b0);
    nxt();
    smp();
    chkb("below_base_valid", rvalid_c, 1'b1);
    chkb("below_base_err", err_c, 1'b1);
    chk ("below_base_rdata", rdata_c, 32'h0);
    nxt();
    smp();
    chkb("mid_c10_rvalid", rvalid_c, 1'b0);
    nxt();
    rst_c = 1'b0;

    // Periodic grant stall (only when the feature is compiled in)
    rst_d = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0;
    for (int c = 0; c < 12; c++) begin
`ifdef IBEX_DMEM_RESP_GNT_STALL_EN
      eg = ((c % 4) != 3);
`else
      eg = 1'b1;
`endif
      smp();
      chkb("stall_gnt", gnt_d, eg);
      nxt();
    end
    req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
